// File: rtl/mandel_sched_pkg.sv
// rtl/mandel_sched_pkg.sv - shared types and widths for the Mandelbrot pipe scheduler
package mandel_sched_pkg;

  localparam int COORD_W = 16;
  localparam int DIV_W   = 8;
  localparam int TAG_W   = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [TAG_W-1:0] tag;
  } slot_t;

endpackage

// File: rtl/sched_tag_ring.sv
// rtl/sched_tag_ring.sv - slot ownership ring that shifts in lockstep with diverge_pipe
module sched_tag_ring
  import mandel_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  Clk,
  input  logic  Rst,
  input  logic  stage,
  input  slot_t wr_slot,
  output slot_t head,
  output logic  any_valid
);

  slot_t ring_q [DEPTH];
  slot_t ring_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ring_d[i] = ring_q[i];
    if (stage) begin
      ring_d[0] = wr_slot;
      for (int i = 1; i < DEPTH; i++) ring_d[i] = ring_q[i-1];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= ring_d[i];
    end
  end

  // The oldest entry lines up with the pipe's output registers.
  assign head = ring_q[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | ring_q[i].valid;
  end

endmodule

// File: rtl/mandel_pipe_sched.sv
// rtl/mandel_pipe_sched.sv - keeps diverge_pipe full, recirculates live points, retires escapes
// Optional counters: MANDEL_SCHED_STATS_EN
module mandel_pipe_sched
  import mandel_sched_pkg::*;
#(
  parameter int PIPE_DEPTH = 8,
  parameter int MAX_ITER   = 255
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_c1,
  input  logic [COORD_W-1:0] pix_c2,
  input  logic [TAG_W-1:0]   pix_tag,
  input  logic               pix_last,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] c1,
  output logic [COORD_W-1:0] c2,
  output logic [DIV_W-1:0]   div,
  output logic               no_op,
  output logic               stage,
  input  logic [COORD_W-1:0] newX,
  input  logic [COORD_W-1:0] newY,
  input  logic [COORD_W-1:0] newC1,
  input  logic [COORD_W-1:0] newC2,
  input  logic [DIV_W-1:0]   newDiv,
  input  logic               new_no_op,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TAG_W-1:0]   res_tag,
  output logic [DIV_W-1:0]   res_div,
  output logic               busy,
  output logic               frame_done
`ifdef MANDEL_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_retired,
  output logic [31:0]        stat_occ
`endif
);

  localparam logic [DIV_W-1:0] MAX_DIV = DIV_W'(MAX_ITER);

  state_t state_q, state_d;
  slot_t  head, wr_slot;
  logic   any_valid, head_done, retire, slot_free, accept;

  sched_tag_ring #(.DEPTH(PIPE_DEPTH)) u_ring (
    .Clk       (Clk),
    .Rst       (Rst),
    .stage     (stage),
    .wr_slot   (wr_slot),
    .head      (head),
    .any_valid (any_valid)
  );

  // An entry with done=0 was issued with no_op=0, so new_no_op here means a real escape.
  assign head_done = head.valid && (head.done || new_no_op || (newDiv >= MAX_DIV));
  assign retire    = head_done && res_ready;
  assign slot_free = !head.valid || retire;
  assign pix_ready = (state_q == ST_RUN) && slot_free;
  assign accept    = pix_ready && pix_valid;

  assign res_valid = head_done;
  assign res_tag   = head.tag;
  assign res_div   = (newDiv >= MAX_DIV) ? MAX_DIV : newDiv;
  assign busy      = (state_q != ST_IDLE);
  assign stage     = busy;

  always_comb begin
    x       = '0;
    y       = '0;
    c1      = '0;
    c2      = '0;
    div     = '0;
    no_op   = 1'b1;
    wr_slot = '0;
    if (head.valid && !head_done) begin
      x = newX; y = newY; c1 = newC1; c2 = newC2; div = newDiv;
      no_op         = 1'b0;
      wr_slot.valid = 1'b1;
      wr_slot.tag   = head.tag;
    end else if (head_done && !res_ready) begin
      // Frozen lap: the point comes back to the head one pipe depth later.
      x = newX; y = newY; c1 = newC1; c2 = newC2; div = res_div;
      wr_slot.valid = 1'b1;
      wr_slot.done  = 1'b1;
      wr_slot.tag   = head.tag;
    end else if (accept) begin
      c1            = pix_c1;
      c2            = pix_c2;
      no_op         = 1'b0;
      wr_slot.valid = 1'b1;
      wr_slot.tag   = pix_tag;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && pix_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!any_valid) begin
        state_d    = ST_IDLE;
        frame_done = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

`ifdef MANDEL_SCHED_STATS_EN
  logic [31:0] stat_retired_q, stat_retired_d, stat_occ_q, stat_occ_d;

  always_comb begin
    stat_retired_d = stat_retired_q;
    stat_occ_d     = stat_occ_q;
    if (state_q == ST_IDLE && start) begin
      stat_retired_d = '0;
      stat_occ_d     = '0;
    end else begin
      if (retire)     stat_retired_d = stat_retired_q + 32'd1;
      if (head.valid) stat_occ_d     = stat_occ_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stat_retired_q <= '0;
      stat_occ_q     <= '0;
    end else begin
      stat_retired_q <= stat_retired_d;
      stat_occ_q     <= stat_occ_d;
    end
  end

  assign stat_retired = stat_retired_q;
  assign stat_occ     = stat_occ_q;
`endif

endmodule
